prio_mixer: RTL and testbench

Per-pixel layer mixer downstream of the priority PROM (AM27S21A, 256x4). Stage 1 captures the FIX, A, B and OBJ pixels, derives their transparency flags, and drives the PROM address. Stage 2 samples the PROM answer and selects the winning pixel. The result is a registered palette RAM address plus shadow and valid flags. The block sits between the K051962/K051960 pixel outputs and the palette RAM.

---
 rtl/prio_pkg.sv | 27 ++
 rtl/prio_settle_cnt.sv | 46 ++++
 rtl/prio_mixer.sv | 134 +++++++++++++
 tb/tb_prio_mixer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared encodings for the priority mixer: layer numbers, PROM data bits and
// the PROM address bit map.
package prio_pkg;

    typedef enum logic [1:0] {
        LYR_FIX = 2'd0,
        LYR_A   = 2'd1,
        LYR_B   = 2'd2,
        LYR_OBJ = 2'd3
    } layer_e;

    localparam int Q_SHADOW   = 2;
    localparam int Q_BACKDROP = 3;

    localparam int ADR_NVA  = 0;
    localparam int ADR_NVB  = 1;
    localparam int ADR_NOBJ = 2;
    localparam int ADR_NFIX = 3;
    localparam int ADR_OBP2 = 4;
    localparam int ADR_OBP1 = 5;
    localparam int ADR_OBP0 = 6;

    function automatic logic opaque(input logic [3:0] idx);
        return idx != 4'h0;
    endfunction

endpackage

// File: rtl/prio_settle_cnt.sv
// PROM settle timer: reloads on every pixel strobe, counts down to zero, and
// latches an error when a strobe arrives before the count has expired.
module prio_settle_cnt #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic err
);

    generate
        if (SETTLE == 0) begin : g_none
            assign err = 1'b0;
        end else begin : g_cnt
            localparam int CW = $clog2(SETTLE + 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          err_q, err_d;
            logic          cnt_zero;

            assign cnt_zero = (cnt_q == '0);

            always_comb begin
                cnt_d = cnt_zero ? cnt_q : cnt_q - 1'b1;
                err_d = err_q | (load & ~cnt_zero);
                if (load) begin
                    cnt_d = CW'(SETTLE);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    err_q <= err_d;
                end
            end

            assign err = err_q;
        end
    endgenerate

endmodule

// File: rtl/prio_mixer.sv
// Two-stage layer mixer: stage 1 captures pixels and drives the priority PROM,
// stage 2 uses the PROM answer to pick the winning pixel for the palette RAM.
module prio_mixer
    import prio_pkg::*;
#(
    parameter int PX_W   = 8,
    parameter int SETTLE = 2
) (
    input  logic            CLK,
    input  logic            RESn,
    input  logic            PXLEN,
    input  logic            BLANKn,
    input  logic [PX_W-1:0] FIX_PX,
    input  logic [PX_W-1:0] VA_PX,
    input  logic [PX_W-1:0] VB_PX,
    input  logic [PX_W-1:0] OBJ_PX,
    input  logic [2:0]      OBJ_PRI,
    output logic [7:0]      PROM_ADDR,
    output logic            PROM_EN1n,
    output logic            PROM_EN2n,
    input  logic [3:0]      PROM_Q,
    output logic [PX_W+1:0] PAL_ADDR,
    output logic            PAL_SHADOW,
    output logic            PAL_VALID,
    output logic            SETTLE_ERR
);

    localparam logic [PX_W-1:0] IDX_MASK = PX_W'(4'hF);

    logic [PX_W-1:0] layer_in [4];
    logic [3:0]      opaque_in;
    logic [7:0]      addr_in;

    logic [PX_W-1:0] px_q [4];
    logic [PX_W-1:0] px_d [4];
    logic            blank_q, blank_d;
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      prom_addr_q, prom_addr_d;
    logic [PX_W+1:0] pal_addr_q, pal_addr_d;
    logic            pal_shadow_q, pal_shadow_d;
    logic            pal_valid_q, pal_valid_d;

    logic [PX_W-1:0] sel_px;
    logic            out_ok;

    assign layer_in[int'(LYR_FIX)] = FIX_PX;
    assign layer_in[int'(LYR_A)]   = VA_PX;
    assign layer_in[int'(LYR_B)]   = VB_PX;
    assign layer_in[int'(LYR_OBJ)] = OBJ_PX;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_opaque
            assign opaque_in[gi] = opaque(layer_in[gi][3:0]);
        end
    endgenerate

    // Priority bits go in reversed order: OBP0 lands on the highest used bit.
    always_comb begin
        addr_in           = 8'h00;
        addr_in[ADR_NVA]  = opaque_in[int'(LYR_A)];
        addr_in[ADR_NVB]  = opaque_in[int'(LYR_B)];
        addr_in[ADR_NOBJ] = opaque_in[int'(LYR_OBJ)];
        addr_in[ADR_NFIX] = opaque_in[int'(LYR_FIX)];
        addr_in[ADR_OBP2] = OBJ_PRI[2];
        addr_in[ADR_OBP1] = OBJ_PRI[1];
        addr_in[ADR_OBP0] = OBJ_PRI[0];
    end

    always_comb begin
        px_d         = px_q;
        blank_d      = blank_q;
        s1_valid_d   = s1_valid_q;
        prom_addr_d  = prom_addr_q;
        pal_addr_d   = pal_addr_q;
        pal_shadow_d = pal_shadow_q;
        pal_valid_d  = pal_valid_q;

        sel_px = px_q[PROM_Q[1:0]];
        if (PROM_Q[Q_BACKDROP]) begin
            sel_px = sel_px & ~IDX_MASK;
        end
        out_ok = s1_valid_q & blank_q;

        if (PXLEN) begin
            px_d         = layer_in;
            blank_d      = BLANKn;
            s1_valid_d   = 1'b1;
            prom_addr_d  = addr_in;
            pal_addr_d   = out_ok ? {PROM_Q[1:0], sel_px} : '0;
            pal_shadow_d = out_ok & PROM_Q[Q_SHADOW];
            pal_valid_d  = out_ok;
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            for (int i = 0; i < 4; i++) begin
                px_q[i] <= '0;
            end
            blank_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            prom_addr_q  <= 8'h00;
            pal_addr_q   <= '0;
            pal_shadow_q <= 1'b0;
            pal_valid_q  <= 1'b0;
        end else begin
            px_q         <= px_d;
            blank_q      <= blank_d;
            s1_valid_q   <= s1_valid_d;
            prom_addr_q  <= prom_addr_d;
            pal_addr_q   <= pal_addr_d;
            pal_shadow_q <= pal_shadow_d;
            pal_valid_q  <= pal_valid_d;
        end
    end

    prio_settle_cnt #(
        .SETTLE(SETTLE)
    ) u_settle (
        .clk  (CLK),
        .rst_n(RESn),
        .load (PXLEN),
        .err  (SETTLE_ERR)
    );

    assign PROM_ADDR  = prom_addr_q;
    assign PROM_EN1n  = ~RESn;
    assign PROM_EN2n  = ~RESn;
    assign PAL_ADDR   = pal_addr_q;
    assign PAL_SHADOW = pal_shadow_q;
    assign PAL_VALID  = pal_valid_q;

endmodule

// File: tb/tb_prio_mixer.sv
// Randomized bench for prio_mixer with a table-driven PROM and a pixel-level
// reference model of the two-strobe pipeline.
module tb_prio_mixer;

    localparam int PX_W   = 8;
    localparam int SETTLE = 2;

    logic       CLK = 1'b0;
    logic       RESn = 1'b0;
    logic       PXLEN = 1'b0;
    logic       BLANKn = 1'b0;
    logic [7:0] FIX_PX = '0;
    logic [7:0] VA_PX = '0;
    logic [7:0] VB_PX = '0;
    logic [7:0] OBJ_PX = '0;
    logic [2:0] OBJ_PRI = '0;
    logic [7:0] PROM_ADDR;
    logic       PROM_EN1n, PROM_EN2n;
    logic [3:0] PROM_Q;
    logic [9:0] PAL_ADDR;
    logic       PAL_SHADOW, PAL_VALID, SETTLE_ERR;

    logic [3:0] prom_tbl [256];
    assign PROM_Q = prom_tbl[PROM_ADDR];

    prio_mixer #(
        .PX_W  (PX_W),
        .SETTLE(SETTLE)
    ) dut (
        .CLK       (CLK),
        .RESn      (RESn),
        .PXLEN     (PXLEN),
        .BLANKn    (BLANKn),
        .FIX_PX    (FIX_PX),
        .VA_PX     (VA_PX),
        .VB_PX     (VB_PX),
        .OBJ_PX    (OBJ_PX),
        .OBJ_PRI   (OBJ_PRI),
        .PROM_ADDR (PROM_ADDR),
        .PROM_EN1n (PROM_EN1n),
        .PROM_EN2n (PROM_EN2n),
        .PROM_Q    (PROM_Q),
        .PAL_ADDR  (PAL_ADDR),
        .PAL_SHADOW(PAL_SHADOW),
        .PAL_VALID (PAL_VALID),
        .SETTLE_ERR(SETTLE_ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobe = 0;

    // Reference state: what the previous strobe left in the pipeline.
    logic       m_valid;
    logic [7:0] m_lay [4];
    logic       m_blank;
    logic [7:0] m_addr;
    logic       m_err;
    logic       m_loaded;
    int         m_dist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rpx();
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 2) == 0) v[3:0] = 4'h0;
        return v;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_blank  = 1'b0;
        m_addr   = 8'h00;
        m_err    = 1'b0;
        m_loaded = 1'b0;
        m_dist   = 0;
        for (int i = 0; i < 4; i++) m_lay[i] = 8'h00;
    endtask

    task automatic do_reset(input int hold);
        @(posedge CLK);
        #3 RESn = 1'b0;
        PXLEN = 1'b0;
        #1;
        check("rst_pal_addr", 32'(PAL_ADDR), 32'h0);
        check("rst_pal_shadow", 32'(PAL_SHADOW), 32'h0);
        check("rst_pal_valid", 32'(PAL_VALID), 32'h0);
        check("rst_prom_addr", 32'(PROM_ADDR), 32'h0);
        check("rst_en1n", 32'(PROM_EN1n), 32'h1);
        check("rst_en2n", 32'(PROM_EN2n), 32'h1);
        check("rst_settle_err", 32'(SETTLE_ERR), 32'h0);
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        RESn = 1'b1;
        model_reset();
        $display("reset released at %0t", $time);
    endtask

    task automatic strobe(input logic [7:0] f, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] o, input logic [2:0] pri, input logic bl,
                          input int idle);
        logic [3:0] q;
        logic [1:0] lyr;
        logic [7:0] px;
        logic [9:0] e_pal;
        logic       e_sh, e_v;
        logic [7:0] e_addr;

        @(negedge CLK);
        FIX_PX  = f;
        VA_PX   = a;
        VB_PX   = b;
        OBJ_PX  = o;
        OBJ_PRI = pri;
        BLANKn  = bl;
        PXLEN   = 1'b1;

        q = prom_tbl[m_addr];
        if (m_valid && m_blank) begin
            lyr = q[1:0];
            px  = m_lay[lyr];
            if (q[3]) px = {px[7:4], 4'h0};
            e_pal = {lyr, px};
            e_sh  = q[2];
            e_v   = 1'b1;
        end else begin
            e_pal = 10'h0;
            e_sh  = 1'b0;
            e_v   = 1'b0;
        end
        if (m_loaded && m_dist <= SETTLE) m_err = 1'b1;
        e_addr = {1'b0, pri[0], pri[1], pri[2],
                  f[3:0] != 4'h0, o[3:0] != 4'h0, b[3:0] != 4'h0, a[3:0] != 4'h0};

        @(posedge CLK);
        #1 PXLEN = 1'b0;
        n_strobe++;
        check("pal_addr", 32'(PAL_ADDR), 32'(e_pal));
        check("pal_shadow", 32'(PAL_SHADOW), 32'(e_sh));
        check("pal_valid", 32'(PAL_VALID), 32'(e_v));
        check("prom_addr", 32'(PROM_ADDR), 32'(e_addr));
        check("settle_err", 32'(SETTLE_ERR), 32'(m_err));
        check("prom_en", 32'({PROM_EN1n, PROM_EN2n}), 32'h0);
        $display("strobe %0d: prom_addr=%02h pal_addr=%03h shadow=%0b valid=%0b err=%0b",
                 n_strobe, PROM_ADDR, PAL_ADDR, PAL_SHADOW, PAL_VALID, SETTLE_ERR);

        m_valid  = 1'b1;
        m_lay    = '{f, a, b, o};
        m_blank  = bl;
        m_addr   = e_addr;
        m_loaded = 1'b1;
        m_dist   = 1;
        repeat (idle) begin
            @(posedge CLK);
            m_dist++;
        end
    endtask

    task automatic rand_strobe(input logic bl, input int idle);
        strobe(rpx(), rpx(), rpx(), rpx(), 3'($urandom_range(0, 7)), bl, idle);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prom_tbl[i] = 4'($urandom_range(0, 15));
        model_reset();

        do_reset(3);

        // First strobe after reset is never valid, the second one is.
        rand_strobe(1'b1, 3);
        check("first_strobe_valid", 32'(PAL_VALID), 32'h0);
        rand_strobe(1'b1, 3);
        check("second_strobe_valid", 32'(PAL_VALID), 32'h1);

        prom_tbl[8'h55] = 4'h1;
        strobe(8'h00, 8'h13, 8'h00, 8'h27, 3'b101, 1'b1, 3);
        check("addr_map", 32'(PROM_ADDR), 32'h55);
        strobe(8'h00, 8'h13, 8'h00, 8'h27, 3'b101, 1'b1, 3);
        check("select_addr", 32'(PAL_ADDR), 32'h113);
        check("select_shadow", 32'(PAL_SHADOW), 32'h0);
        prom_tbl[8'h55] = 4'hF;
        rand_strobe(1'b1, 3);
        check("backdrop_addr", 32'(PAL_ADDR), 32'h320);
        check("backdrop_shadow", 32'(PAL_SHADOW), 32'h1);

        rand_strobe(1'b0, 3);
        rand_strobe(1'b1, 3);
        check("blank_addr", 32'(PAL_ADDR), 32'h0);
        check("blank_valid", 32'(PAL_VALID), 32'h0);
        rand_strobe(1'b1, 3);
        check("after_blank_valid", 32'(PAL_VALID), 32'h1);

        for (int i = 0; i < 120; i++) begin
            rand_strobe($urandom_range(0, 7) != 0, int'($urandom_range(2, 4)));
        end

        do_reset(2);
        rand_strobe(1'b1, 3);
        rand_strobe(1'b1, 3);

        // Back-to-back strobes violate the settle time.
        rand_strobe(1'b1, 0);
        rand_strobe(1'b1, 3);
        check("settle_err_set", 32'(SETTLE_ERR), 32'h1);
        for (int i = 0; i < 5; i++) rand_strobe(1'b1, 3);
        check("settle_err_sticky", 32'(SETTLE_ERR), 32'h1);

        do_reset(2);
        for (int i = 0; i < 20; i++) rand_strobe(1'b1, 3);
        check("settle_err_clear", 32'(SETTLE_ERR), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
